// File: rtl/or4_event_arbiter.sv
// ---------------------------------------------------------------------------
// or4_event_arbiter
//   Turns the WIDTH-bit level vector coming out of the Or4x4 OR-reduction
//   stage into a serialized stream of event indices. Rising edges are caught
//   as sticky pending flags. The flags are served one at a time in
//   round-robin order through a registered valid/ready output.
//
//   Optional build macro: OR4_EVT_DROPCNT_EN
//     When this macro is defined, the drop_cnt/drop_clr ports are added. The
//     design then counts coalesced events, which are rises on a line whose
//     pending flag is already set. The count saturates at 2^CNT_W-1.
// ---------------------------------------------------------------------------
module or4_event_arbiter #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [WIDTH-1:0] I,
  output logic             O_valid,
  input  logic             O_ready,
  output logic [IDX_W-1:0] O_idx,
  output logic [WIDTH-1:0] O_pending
`ifdef OR4_EVT_DROPCNT_EN
  ,
  output logic [CNT_W-1:0] drop_cnt,
  input  logic             drop_clr
`endif
);

  // Parameter sanity: the index must address every line exactly.
  if (IDX_W != $clog2(WIDTH)) begin : g_bad_idx_w
    $error("IDX_W must equal clog2(WIDTH)");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(WIDTH - 1);

  // State registers.
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] pending_q;
  logic             valid_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] ptr_q;

  // Combinational helpers.
  logic [WIDTH-1:0] rise;
  logic             load;
  logic             grant_found;
  logic [IDX_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_mask;
  logic [WIDTH-1:0] pending_next;

  assign rise = I & ~prev_q;

  // The output register can take a new event when it is empty, or when its
  // current event is being accepted in this cycle.
  assign load = !valid_q || O_ready;

  // Round-robin search of the pending register. The search starts at the
  // line after the last grant and wraps around. The first set bit wins.
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= WIDTH; k++) begin
      cand = (int'(ptr_q) + k) % WIDTH;
      if (!grant_found && pending_q[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  // One-hot clear mask for the line that moves into the output register.
  always_comb begin
    grant_mask = '0;
    if (load && grant_found) begin
      grant_mask[grant_idx] = 1'b1;
    end
  end

  // The grant clears the line before the new rises are ORed in. A rise on
  // the line granted in the same cycle is a new occurrence, so the rise
  // keeps that flag set.
  assign pending_next = (pending_q & ~grant_mask) | rise;

  // Edge detector, pending flags, and registered output stage.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      prev_q    <= I;
      pending_q <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      ptr_q     <= PTR_RST;
    end else begin
      prev_q    <= I;
      pending_q <= pending_next;
      if (load) begin
        if (grant_found) begin
          valid_q <= 1'b1;
          idx_q   <= grant_idx;
          ptr_q   <= grant_idx;
        end else begin
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign O_valid   = valid_q;
  assign O_idx     = idx_q;
  assign O_pending = pending_q;

`ifdef OR4_EVT_DROPCNT_EN
  localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  logic [WIDTH-1:0] coalesced;
  logic [CNT_W:0]   drop_inc;
  logic [CNT_W:0]   drop_sum;
  logic [CNT_W-1:0] drop_q;

  assign coalesced = rise & pending_q;

  // Count the coalesced events of this cycle.
  always_comb begin
    drop_inc = '0;
    for (int k = 0; k < WIDTH; k++) begin
      drop_inc = drop_inc + (CNT_W+1)'(coalesced[k]);
    end
  end

  assign drop_sum = {1'b0, drop_q} + drop_inc;

  // Saturating accumulator. A clear restarts the count from this cycle's
  // coalesced events, so events seen during the clear are not lost.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      drop_q <= '0;
    end else if (drop_clr) begin
      drop_q <= (drop_inc > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : drop_inc[CNT_W-1:0];
    end else begin
      drop_q <= (drop_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : drop_sum[CNT_W-1:0];
    end
  end

  assign drop_cnt = drop_q;
`endif

endmodule
